// File: rtl/ara_inval_scheduler_pkg.sv
// ara_inval_scheduler_pkg: shared types, sizes and helpers for the L1 invalidation scheduler
//   AddrWidth   - byte address width of requests and invalidations
//   L1LineWidth - L1 D-cache line size in bytes (power of two, >=4)
//   Depth       - request FIFO entries (power of two, >=2)
//   MaxLines    - largest line count a single request may expand into
package ara_inval_scheduler_pkg;
   localparam int unsigned AddrWidth   = 64;
   localparam int unsigned L1LineWidth = 16;
   localparam int unsigned Depth       = 4;
   localparam int unsigned MaxLines    = 8;
   localparam int unsigned LinesW      = $clog2(MaxLines + 1);
   typedef logic [AddrWidth-1:0] addr_t;
   typedef logic [LinesW-1:0]    lines_t;
   typedef struct packed {
      addr_t  addr;
      lines_t lines;
   } inval_req_t;
   typedef enum logic [1:0] {IDLE, ISSUE, SKIP} inval_state_e;
   // 0 lines still means "invalidate the line holding addr"; oversize requests saturate
   function automatic lines_t clamp_lines(input lines_t l);
      return (l == '0) ? lines_t'(1) : ((l > lines_t'(MaxLines)) ? lines_t'(MaxLines) : l);
   endfunction
   function automatic addr_t line_align(input addr_t a);
      return a & ~addr_t'(L1LineWidth - 1);
   endfunction
endpackage

// File: rtl/ara_inval_scheduler_fifo.sv
// ara_inval_scheduler_fifo: Depth-entry request FIFO with fifo_v3-style interface
//   clk_i   in  clock
//   rst_ni  in  asynchronous reset, active-low
//   flush_i in  synchronous clear of all entries
//   push_i  in  write data_i (ignored when full)
//   data_i  in  request to enqueue
//   pop_i   in  drop head entry (ignored when empty)
//   full_o  out no free entry
//   empty_o out no valid entry
//   data_o  out head entry
module ara_inval_scheduler_fifo
   import ara_inval_scheduler_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush_i,
   input  logic       push_i,
   input  inval_req_t data_i,
   input  logic       pop_i,
   output logic       full_o,
   output logic       empty_o,
   output inval_req_t data_o
);
   localparam int unsigned PtrW = $clog2(Depth);
   inval_req_t       r_mem [Depth];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [PtrW:0]    r_cnt;
   logic             w_push;
   logic             w_pop;
   always_comb begin
      full_o  = (r_cnt == (PtrW+1)'(Depth));
      empty_o = (r_cnt == '0);
      w_push  = push_i & ~full_o;
      w_pop   = pop_i & ~empty_o;
      data_o  = r_mem[r_rptr];
   end
   // pointers wrap naturally because Depth is a power of two
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (flush_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PtrW'(1);
         if (w_pop) r_rptr <= r_rptr + PtrW'(1);
         r_cnt <= r_cnt + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= data_i;
   end
endmodule

// File: rtl/ara_inval_scheduler.sv
// ara_inval_scheduler: expands queued (base, line count) requests into one L1 line invalidation per cycle
//   clk_i          in  clock
//   rst_i          in  asynchronous reset, active-high
//   en_i           in  coherence enable; when low new requests are accepted and dropped
//   req_valid_i    in  invalidation request valid
//   req_ready_o    out request accepted when valid & ready (FIFO not full)
//   req_addr_i     in  request base byte address, any alignment
//   req_lines_i    in  line count (0 -> 1, above MaxLines -> MaxLines)
//   inval_valid_o  out invalidation valid toward CVA6
//   inval_ready_i  in  CVA6 accepts invalidation
//   inval_addr_o   out line-aligned invalidation address
//   busy_o         out queued or in-progress work
module ara_inval_scheduler
   import ara_inval_scheduler_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [LinesW-1:0]    req_lines_i,
   output logic                 inval_valid_o,
   input  logic                 inval_ready_i,
   output logic [AddrWidth-1:0] inval_addr_o,
   output logic                 busy_o
);
   inval_state_e r_state;
   inval_state_e w_state_nxt;
   addr_t        r_cur;
   addr_t        w_cur_nxt;
   lines_t       r_rem;
   lines_t       w_rem_nxt;
   addr_t        r_last;
   addr_t        w_last_nxt;
   logic         r_last_vld;
   logic         w_last_vld_nxt;
   logic         w_full;
   logic         w_empty;
   logic         w_pop;
   logic         w_hs;
   logic         w_step;
   logic         w_done;
   logic         w_dup;
   addr_t        w_head_line;
   inval_req_t   w_head;
   inval_req_t   w_push_req;
   assign w_push_req = '{addr: req_addr_i, lines: req_lines_i};
   ara_inval_scheduler_fifo u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (~rst_i),
      .flush_i (1'b0),
      .push_i  (req_valid_i & en_i),
      .data_i  (w_push_req),
      .pop_i   (w_pop),
      .full_o  (w_full),
      .empty_o (w_empty),
      .data_o  (w_head)
   );
   always_comb begin
      w_hs           = (r_state == ISSUE) & inval_ready_i;
      w_step         = w_hs | (r_state == SKIP);
      w_done         = w_step & (r_rem == lines_t'(1));
      w_last_nxt     = w_hs ? r_cur : r_last;
      w_last_vld_nxt = en_i & (w_hs | r_last_vld);
      // finishing a request pops the next one in the same cycle so there is no bubble
      w_pop          = ~w_empty & ((r_state == IDLE) | w_done);
      w_head_line    = line_align(w_head.addr);
      // compare against the line being retired this cycle, so back-to-back duplicates are caught
      w_dup          = w_last_vld_nxt & (w_head_line == w_last_nxt);
      w_state_nxt    = w_pop ? (w_dup ? SKIP : ISSUE) : w_done ? IDLE : w_step ? ISSUE : r_state;
      w_cur_nxt      = w_pop ? w_head_line : w_step ? r_cur + addr_t'(L1LineWidth) : r_cur;
      w_rem_nxt      = w_pop ? clamp_lines(w_head.lines) : w_step ? r_rem - lines_t'(1) : r_rem;
      req_ready_o    = ~w_full;
      inval_valid_o  = (r_state == ISSUE);
      inval_addr_o   = inval_valid_o ? r_cur : '0;
      busy_o         = ~w_empty | (r_state != IDLE);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_cur      <= '0;
         r_rem      <= '0;
         r_last     <= '0;
         r_last_vld <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cur      <= w_cur_nxt;
         r_rem      <= w_rem_nxt;
         r_last     <= w_last_nxt;
         r_last_vld <= w_last_vld_nxt;
      end
   end
endmodule

// File: tb/tb_ara_inval_scheduler.sv
// tb_ara_inval_scheduler: directed vector table plus hand sequences for the invalidation scheduler
module tb_ara_inval_scheduler;
   import ara_inval_scheduler_pkg::*;
   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 en = 1'b0;
   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic [AddrWidth-1:0] req_addr = '0;
   logic [LinesW-1:0]    req_lines = '0;
   logic                 inval_valid;
   logic                 inval_ready = 1'b0;
   logic [AddrWidth-1:0] inval_addr;
   logic                 busy;
   int                   n_chk = 0;
   int                   n_fail = 0;
   typedef struct {
      logic        en;
      logic        v;
      logic [63:0] a;
      logic [3:0]  l;
      logic        rdy;
      logic        e_rr;
      logic        e_vld;
      logic [63:0] e_addr;
      logic        e_busy;
   } vec_t;
   vec_t tv[$];
   ara_inval_scheduler dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (en),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_addr_i    (req_addr),
      .req_lines_i   (req_lines),
      .inval_valid_o (inval_valid),
      .inval_ready_i (inval_ready),
      .inval_addr_o  (inval_addr),
      .busy_o        (busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   function automatic vec_t mk(input logic e, input logic v, input logic [63:0] a, input logic [3:0] l,
                               input logic rdy, input logic vld, input logic [63:0] ea, input logic bsy);
      mk = '{e, v, a, l, rdy, 1'b1, vld, ea, bsy};
   endfunction
   // drain with inval_ready held high: count issued lines and remember the last one
   task automatic drain(output int n, output logic [63:0] last);
      n = 0;
      last = '0;
      for (int c = 0; c < 30; c++) begin
         if (inval_valid) begin
            n++;
            last = inval_addr;
         end
         step();
      end
   endtask
   initial begin
      int          got;
      logic [63:0] seen [5];
      logic [63:0] last;
      // reset state
      step();
      chk("reset ready", req_ready, 1);
      chk("reset valid", inval_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset addr", inval_addr, 0);
      rst = 1'b0;
      en  = 1'b1;
      // unaligned 3-line request
      tv.push_back(mk(1, 1, 64'h1004, 3, 1, 0, 64'h0, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 1, 64'h1000, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 1, 64'h1010, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 1, 64'h1020, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 0, 64'h0, 0));
      // back-to-back overlap: second 0x2010 skipped in one SKIP cycle
      tv.push_back(mk(1, 1, 64'h2000, 2, 1, 0, 64'h0, 1));
      tv.push_back(mk(1, 1, 64'h2010, 2, 1, 1, 64'h2000, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 1, 64'h2010, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 0, 64'h0, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 1, 64'h2020, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 0, 64'h0, 0));
      // address wrap
      tv.push_back(mk(1, 1, 64'hFFFF_FFFF_FFFF_FFF0, 2, 1, 0, 64'h0, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 1, 64'h0, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 0, 64'h0, 0));
      // lines=0 gives one invalidation
      tv.push_back(mk(1, 1, 64'h40, 0, 1, 0, 64'h0, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 1, 64'h40, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 0, 64'h0, 0));
      // single-line duplicate of last line: SKIP straight back to IDLE
      tv.push_back(mk(1, 1, 64'h44, 1, 1, 0, 64'h0, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 0, 64'h0, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 0, 64'h0, 0));
      // disabled: accepted and dropped, and last line forgotten
      tv.push_back(mk(0, 1, 64'h3000, 2, 1, 0, 64'h0, 0));
      tv.push_back(mk(0, 0, 64'h0, 0, 1, 0, 64'h0, 0));
      tv.push_back(mk(1, 1, 64'h40, 1, 1, 0, 64'h0, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 1, 64'h40, 1));
      tv.push_back(mk(1, 0, 64'h0, 0, 1, 0, 64'h0, 0));
      foreach (tv[i]) begin
         en          = tv[i].en;
         req_valid   = tv[i].v;
         req_addr    = tv[i].a;
         req_lines   = tv[i].l;
         inval_ready = tv[i].rdy;
         step();
         chk($sformatf("vec%0d ready", i), req_ready, tv[i].e_rr);
         chk($sformatf("vec%0d valid", i), inval_valid, tv[i].e_vld);
         chk($sformatf("vec%0d addr", i), inval_addr, tv[i].e_addr);
         chk($sformatf("vec%0d busy", i), busy, tv[i].e_busy);
      end
      // fill the FIFO while CVA6 stalls
      en          = 1'b1;
      inval_ready = 1'b0;
      req_lines   = 1;
      for (int k = 0; k < 5; k++) begin
         req_valid = 1'b1;
         req_addr  = 64'h5000 + 64'(k) * 64'h1000;
         step();
         chk($sformatf("fill%0d ready", k), req_ready, (k == 4) ? 1'b0 : 1'b1);
      end
      chk("fill valid", inval_valid, 1);
      chk("fill addr", inval_addr, 64'h5000);
      req_addr = 64'hA000;
      step();
      chk("full refuse ready", req_ready, 0);
      req_valid = 1'b0;
      en = 1'b0;
      repeat (3) step();
      chk("hold valid", inval_valid, 1);
      chk("hold addr", inval_addr, 64'h5000);
      en = 1'b1;
      inval_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         if (inval_valid) begin
            if (got < 5) seen[got] = inval_addr;
            got++;
         end
         step();
      end
      chk("drain count", 64'(got), 5);
      for (int k = 0; k < 5; k++) chk($sformatf("drain%0d addr", k), seen[k], 64'h5000 + 64'(k) * 64'h1000);
      chk("drain busy", busy, 0);
      // oversize line count clamps to MaxLines
      req_valid = 1'b1;
      req_addr  = 64'hC000;
      req_lines = 4'hF;
      step();
      req_valid = 1'b0;
      drain(got, last);
      chk("clamp count", 64'(got), 8);
      chk("clamp last", last, 64'hC070);
      // async reset mid-request
      req_valid = 1'b1;
      req_addr  = 64'hB000;
      req_lines = 4;
      step();
      req_valid = 1'b0;
      step();
      step();
      chk("pre-reset valid", inval_valid, 1);
      chk("pre-reset addr", inval_addr, 64'hB010);
      #2 rst = 1'b1;
      #1;
      chk("async reset valid", inval_valid, 0);
      chk("async reset busy", busy, 0);
      chk("async reset ready", req_ready, 1);
      chk("async reset addr", inval_addr, 0);
      step();
      rst = 1'b0;
      repeat (3) step();
      chk("post-reset valid", inval_valid, 0);
      chk("post-reset busy", busy, 0);
      chk("post-reset ready", req_ready, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
